id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register; sits directly downstream of the 32-entry register file.
- Captures the two read operands, register specifiers, extended immediate and control bits each cycle.
- Closes the register file's write/read gap: write on clk edge, combinational read. It bypasses same-cycle writeback data and forces $0 to read as zero.
- Provides load-use hazard detection, stall/hold and flush/bubble insertion for the pipeline controller.

Parameters:
- DATA_WIDTH, 32, operand and writeback data width
- REG_ADDR_WIDTH, 5, register specifier width
- ALUOP_WIDTH, 4, ALU operation code width

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- Stall  input  1  hold current EX contents
- Flush  input  1  load a bubble into EX
- Readregister1  input  REG_ADDR_WIDTH  rs of decoding instruction
- Readregister2  input  REG_ADDR_WIDTH  rt of decoding instruction
- RdIn  input  REG_ADDR_WIDTH  rd field
- Readdata1  input  DATA_WIDTH  register file port 1 data
- Readdata2  input  DATA_WIDTH  register file port 2 data
- ImmIn  input  16  immediate field
- ExtOp  input  1  1 = sign-extend, 0 = zero-extend
- RegWriteIn, MemReadIn, MemWriteIn, MemtoRegIn, ALUSrcIn, RegDstIn  input  1 each  decode control
- ALUOpIn  input  ALUOP_WIDTH  ALU operation
- WbRegWrite  input  1  writeback write enable (same signal driving register file RegWrite)
- WbWriteregister  input  REG_ADDR_WIDTH  writeback destination
- WbWritedata  input  DATA_WIDTH  writeback data
- ValidEx  output  1  EX holds a real instruction
- RsEx, RtEx, WriteregEx  output  REG_ADDR_WIDTH  latched rs, rt, selected destination
- OperandAEx, OperandBEx  output  DATA_WIDTH  latched operands
- ImmEx  output  DATA_WIDTH  extended immediate
- RegWriteEx, MemReadEx, MemWriteEx, MemtoRegEx, ALUSrcEx  output  1 each  latched control
- ALUOpEx  output  ALUOP_WIDTH  latched ALU op
- LoadUseHazard  output  1  combinational load-use detect

Behaviour:
- Reset: rst_n low asynchronously clears every registered output to 0, including ValidEx. Outputs stay 0 while low. Reset mid-stall or mid-flush discards all state.
- Update priority at a rising edge with rst_n high: Flush > Stall > Load.
- Load:
  - ValidEx <= 1; control and ALUOp copied from inputs.
  - WriteregEx <= RegDstIn ? RdIn : Readregister2.
  - ImmEx <= ExtOp ? {16{ImmIn[15]}, ImmIn} : {16'b0, ImmIn}.
- Operand capture on Load, per port n (1→A, 2→B):
  - If Readregister_n == 0, captured operand = 0.
  - Else if WbRegWrite and WbWriteregister == Readregister_n, captured operand = WbWritedata (bypass).
  - Else captured operand = Readdata_n.
- Flush: ValidEx, RegWriteEx, MemReadEx, MemWriteEx, MemtoRegEx, ALUSrcEx <= 0; ALUOpEx, specifiers, operands and ImmEx <= 0.
- Stall (Flush low): all fields hold, except held operands are refreshed.
  - If WbRegWrite and WbWriteregister != 0 and WbWriteregister == RsEx, OperandAEx <= WbWritedata.
  - Same rule for RtEx and OperandBEx.
  - Both refresh together when RsEx == RtEx.
- WbWriteregister == 0 never bypasses or refreshes.
- LoadUseHazard = ValidEx & MemReadEx & (RtEx != 0) & ((RtEx == Readregister1) | (RtEx == Readregister2)).
  - Purely combinational, no added latency.
  - The controller is expected to drive Stall on the decode side and Flush here.
- Latency: one cycle from decode inputs to EX outputs.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with ValidEx=1 → all outputs 0 immediately; first edge after release loads normally.
- Plain load: Readregister1=3, Readdata1=0x11, Readregister2=4, Readdata2=0x22, RegDstIn=1, RdIn=7, ImmIn=0x8001, ExtOp=1 → next cycle OperandAEx=0x11, OperandBEx=0x22, WriteregEx=7, ImmEx=0xFFFF8001. With ExtOp=0 → ImmEx=0x00008001.
- Bypass and $0:
  - WbRegWrite=1, WbWriteregister=3, WbWritedata=0xDEAD, Readdata1=0x11 (stale), Readregister1=3 → OperandAEx=0xDEAD.
  - Readregister2=0, Readdata2=0x55 → OperandBEx=0.
  - WbWriteregister=0 → no bypass.
- Stall refresh: load RsEx=5, RtEx=5, then Stall=1 with WB writing reg 5 = 0xBEEF → both operands 0xBEEF. All other fields unchanged across 3 stalled cycles.
- Flush vs stall: Stall=1 and Flush=1 same edge → ValidEx=0, all control 0. Next Load restores ValidEx=1.
- Load-use: EX holds MemReadEx=1, RtEx=8.
  - Readregister2=8 → LoadUseHazard=1.
  - RtEx=0 → 0.
  - ValidEx=0 after flush → 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register. Sits directly downstream of a
// 32-entry register file whose writes land on the clock edge while reads are
// combinational, so a value being written back in the same cycle as it is
// read would otherwise be captured stale. This stage closes that gap by
// bypassing writeback data into the captured operands, forces register $0 to
// read as zero, and refreshes held operands while stalled. It also provides
// the combinational load-use hazard detect used by the pipeline controller.
//
// Ports
//   clk, rst_n            pipeline clock / asynchronous active-low reset
//   Stall, Flush          hold EX contents / load a bubble (Flush wins)
//   Readregister1/2       rs / rt of the instruction in decode
//   RdIn                  rd field of the instruction in decode
//   Readdata1/2           register file read data for rs / rt
//   ImmIn, ExtOp          16-bit immediate and sign(1)/zero(0) extend select
//   *In (control)         decode control bits and ALU op
//   WbRegWrite,
//   WbWriteregister,
//   WbWritedata           writeback port, same signals as the register file
//   ValidEx               EX holds a real instruction
//   RsEx, RtEx,
//   WriteregEx            latched specifiers and selected destination
//   OperandAEx/BEx        latched (bypassed) operands
//   ImmEx                 extended immediate
//   *Ex (control)         latched control bits and ALU op
//   LoadUseHazard         combinational load-use detect against decode
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic [REG_ADDR_WIDTH-1:0] Readregister1,
    input  logic [REG_ADDR_WIDTH-1:0] Readregister2,
    input  logic [REG_ADDR_WIDTH-1:0] RdIn,
    input  logic [DATA_WIDTH-1:0]     Readdata1,
    input  logic [DATA_WIDTH-1:0]     Readdata2,
    input  logic [15:0]               ImmIn,
    input  logic                      ExtOp,
    input  logic                      RegWriteIn,
    input  logic                      MemReadIn,
    input  logic                      MemWriteIn,
    input  logic                      MemtoRegIn,
    input  logic                      ALUSrcIn,
    input  logic                      RegDstIn,
    input  logic [ALUOP_WIDTH-1:0]    ALUOpIn,
    input  logic                      WbRegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] WbWriteregister,
    input  logic [DATA_WIDTH-1:0]     WbWritedata,
    output logic                      ValidEx,
    output logic [REG_ADDR_WIDTH-1:0] RsEx,
    output logic [REG_ADDR_WIDTH-1:0] RtEx,
    output logic [REG_ADDR_WIDTH-1:0] WriteregEx,
    output logic [DATA_WIDTH-1:0]     OperandAEx,
    output logic [DATA_WIDTH-1:0]     OperandBEx,
    output logic [DATA_WIDTH-1:0]     ImmEx,
    output logic                      RegWriteEx,
    output logic                      MemReadEx,
    output logic                      MemWriteEx,
    output logic                      MemtoRegEx,
    output logic                      ALUSrcEx,
    output logic [ALUOP_WIDTH-1:0]    ALUOpEx,
    output logic                      LoadUseHazard
);

    localparam int ImmWidth = 16;

    // -----------------------------------------------------------------------
    // Pipeline state
    // -----------------------------------------------------------------------
    logic                      valid_q,    valid_d;
    logic [REG_ADDR_WIDTH-1:0] rs_q,       rs_d;
    logic [REG_ADDR_WIDTH-1:0] rt_q,       rt_d;
    logic [REG_ADDR_WIDTH-1:0] wreg_q,     wreg_d;
    logic [DATA_WIDTH-1:0]     opa_q,      opa_d;
    logic [DATA_WIDTH-1:0]     opb_q,      opb_d;
    logic [DATA_WIDTH-1:0]     imm_q,      imm_d;
    logic                      regwrite_q, regwrite_d;
    logic                      memread_q,  memread_d;
    logic                      memwrite_q, memwrite_d;
    logic                      memtoreg_q, memtoreg_d;
    logic                      alusrc_q,   alusrc_d;
    logic [ALUOP_WIDTH-1:0]    aluop_q,    aluop_d;

    // -----------------------------------------------------------------------
    // Load-path values
    // -----------------------------------------------------------------------
    // A writeback to $0 is architecturally a no-op, so it must never bypass
    // or refresh anything.
    logic                      wb_active;
    logic [DATA_WIDTH-1:0]     opa_load;
    logic [DATA_WIDTH-1:0]     opb_load;
    logic [DATA_WIDTH-1:0]     opa_hold;
    logic [DATA_WIDTH-1:0]     opb_hold;
    logic [DATA_WIDTH-1:0]     imm_load;
    logic [REG_ADDR_WIDTH-1:0] wreg_load;

    assign wb_active = WbRegWrite && (WbWriteregister != '0);

    // Operand A capture: $0 forces zero, then same-cycle writeback bypass.
    always_comb begin
        opa_load = Readdata1;
        if (Readregister1 == '0) begin
            opa_load = '0;
        end else if (wb_active && (WbWriteregister == Readregister1)) begin
            opa_load = WbWritedata;
        end
    end

    // Operand B capture, same rules on port 2.
    always_comb begin
        opb_load = Readdata2;
        if (Readregister2 == '0) begin
            opb_load = '0;
        end else if (wb_active && (WbWriteregister == Readregister2)) begin
            opb_load = WbWritedata;
        end
    end

    // While stalled the register file keeps being written; a held operand
    // whose source register is the writeback target would otherwise go stale.
    // When rs == rt both operands refresh from the same write.
    always_comb begin
        opa_hold = opa_q;
        opb_hold = opb_q;
        if (wb_active && (WbWriteregister == rs_q)) begin
            opa_hold = WbWritedata;
        end
        if (wb_active && (WbWriteregister == rt_q)) begin
            opb_hold = WbWritedata;
        end
    end

    always_comb begin
        if (ExtOp) begin
            imm_load = {{(DATA_WIDTH - ImmWidth){ImmIn[ImmWidth-1]}}, ImmIn};
        end else begin
            imm_load = {{(DATA_WIDTH - ImmWidth){1'b0}}, ImmIn};
        end
    end

    assign wreg_load = RegDstIn ? RdIn : Readregister2;

    // -----------------------------------------------------------------------
    // Next-state selection: Flush > Stall > Load
    // -----------------------------------------------------------------------
    always_comb begin
        // Default is stall: hold everything except the refreshed operands.
        valid_d    = valid_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        wreg_d     = wreg_q;
        opa_d      = opa_hold;
        opb_d      = opb_hold;
        imm_d      = imm_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        alusrc_d   = alusrc_q;
        aluop_d    = aluop_q;

        if (Flush) begin
            valid_d    = 1'b0;
            rs_d       = '0;
            rt_d       = '0;
            wreg_d     = '0;
            opa_d      = '0;
            opb_d      = '0;
            imm_d      = '0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            alusrc_d   = 1'b0;
            aluop_d    = '0;
        end else if (!Stall) begin
            valid_d    = 1'b1;
            rs_d       = Readregister1;
            rt_d       = Readregister2;
            wreg_d     = wreg_load;
            opa_d      = opa_load;
            opb_d      = opb_load;
            imm_d      = imm_load;
            regwrite_d = RegWriteIn;
            memread_d  = MemReadIn;
            memwrite_d = MemWriteIn;
            memtoreg_d = MemtoRegIn;
            alusrc_d   = ALUSrcIn;
            aluop_d    = ALUOpIn;
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            wreg_q     <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            imm_q      <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluop_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            wreg_q     <= wreg_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            imm_q      <= imm_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            alusrc_q   <= alusrc_d;
            aluop_q    <= aluop_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ValidEx    = valid_q;
    assign RsEx       = rs_q;
    assign RtEx       = rt_q;
    assign WriteregEx = wreg_q;
    assign OperandAEx = opa_q;
    assign OperandBEx = opb_q;
    assign ImmEx      = imm_q;
    assign RegWriteEx = regwrite_q;
    assign MemReadEx  = memread_q;
    assign MemWriteEx = memwrite_q;
    assign MemtoRegEx = memtoreg_q;
    assign ALUSrcEx   = alusrc_q;
    assign ALUOpEx    = aluop_q;

    // A load in EX whose destination is a source of the decoding instruction
    // cannot be forwarded in time; $0 is exempt since it always reads zero.
    assign LoadUseHazard = valid_q && memread_q && (rt_q != '0) &&
                           ((rt_q == Readregister1) || (rt_q == Readregister2));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Stall, Flush;
    logic [4:0]  Readregister1, Readregister2, RdIn;
    logic [31:0] Readdata1, Readdata2;
    logic [15:0] ImmIn;
    logic        ExtOp, RegWriteIn, MemReadIn, MemWriteIn, MemtoRegIn, ALUSrcIn, RegDstIn;
    logic [3:0]  ALUOpIn;
    logic        WbRegWrite;
    logic [4:0]  WbWriteregister;
    logic [31:0] WbWritedata;
    logic        ValidEx;
    logic [4:0]  RsEx, RtEx, WriteregEx;
    logic [31:0] OperandAEx, OperandBEx, ImmEx;
    logic        RegWriteEx, MemReadEx, MemWriteEx, MemtoRegEx, ALUSrcEx;
    logic [3:0]  ALUOpEx;
    logic        LoadUseHazard;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush),
        .Readregister1(Readregister1), .Readregister2(Readregister2), .RdIn(RdIn),
        .Readdata1(Readdata1), .Readdata2(Readdata2), .ImmIn(ImmIn), .ExtOp(ExtOp),
        .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .MemtoRegIn(MemtoRegIn), .ALUSrcIn(ALUSrcIn), .RegDstIn(RegDstIn),
        .ALUOpIn(ALUOpIn), .WbRegWrite(WbRegWrite), .WbWriteregister(WbWriteregister),
        .WbWritedata(WbWritedata), .ValidEx(ValidEx), .RsEx(RsEx), .RtEx(RtEx),
        .WriteregEx(WriteregEx), .OperandAEx(OperandAEx), .OperandBEx(OperandBEx),
        .ImmEx(ImmEx), .RegWriteEx(RegWriteEx), .MemReadEx(MemReadEx),
        .MemWriteEx(MemWriteEx), .MemtoRegEx(MemtoRegEx), .ALUSrcEx(ALUSrcEx),
        .ALUOpEx(ALUOpEx), .LoadUseHazard(LoadUseHazard)
    );

    typedef struct packed {
        logic        stall, flush;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2;
        logic [15:0] imm;
        logic        ext, regwrite, memread, memwrite, memtoreg, alusrc, regdst;
        logic [3:0]  aluop;
        logic        wbwe;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, wreg;
        logic [31:0] opa, opb, imm;
        logic        regwrite, memread, memwrite, memtoreg, alusrc;
        logic [3:0]  aluop;
    } ex_t;

    typedef struct packed {
        ex_t  ex;
        logic hazard;
    } exp_t;

    exp_t sb_q[$];
    ex_t  model;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What the register file port effectively delivers for register r.
    function automatic logic [31:0] read_val(input logic [4:0] r, input logic [31:0] d,
                                             input stim_t s);
        if (r == 0) return 32'h0;
        if (s.wbwe && s.wreg == r) return s.wdata;
        return d;
    endfunction

    function automatic ex_t ref_next(input ex_t cur, input stim_t s);
        ex_t n;
        n = cur;
        if (s.flush) begin
            n = '0;
        end else if (s.stall) begin
            if (s.wbwe && s.wreg != 0) begin
                if (s.wreg == cur.rs) n.opa = s.wdata;
                if (s.wreg == cur.rt) n.opb = s.wdata;
            end
        end else begin
            n.valid    = 1'b1;
            n.rs       = s.rs;
            n.rt       = s.rt;
            n.wreg     = s.regdst ? s.rd : s.rt;
            n.opa      = read_val(s.rs, s.d1, s);
            n.opb      = read_val(s.rt, s.d2, s);
            n.imm      = s.ext ? 32'($signed(s.imm)) : 32'(s.imm);
            n.regwrite = s.regwrite;
            n.memread  = s.memread;
            n.memwrite = s.memwrite;
            n.memtoreg = s.memtoreg;
            n.alusrc   = s.alusrc;
            n.aluop    = s.aluop;
        end
        return n;
    endfunction

    function automatic logic ref_hazard(input ex_t e, input logic [4:0] rs, input logic [4:0] rt);
        return e.valid && e.memread && e.rt != 0 && (e.rt == rs || e.rt == rt);
    endfunction

    // One decode cycle: drive at the falling edge, predict the EX contents
    // after the next rising edge.
    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        Stall = s.stall; Flush = s.flush;
        Readregister1 = s.rs; Readregister2 = s.rt; RdIn = s.rd;
        Readdata1 = s.d1; Readdata2 = s.d2; ImmIn = s.imm; ExtOp = s.ext;
        RegWriteIn = s.regwrite; MemReadIn = s.memread; MemWriteIn = s.memwrite;
        MemtoRegIn = s.memtoreg; ALUSrcIn = s.alusrc; RegDstIn = s.regdst; ALUOpIn = s.aluop;
        WbRegWrite = s.wbwe; WbWriteregister = s.wreg; WbWritedata = s.wdata;
        model = ref_next(model, s);
        e.ex = model;
        e.hazard = ref_hazard(model, s.rs, s.rt);
        sb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(ValidEx), 0);
        check({tag, "_opa"}, OperandAEx, 0);
        check({tag, "_opb"}, OperandBEx, 0);
        check({tag, "_imm"}, ImmEx, 0);
        check({tag, "_regs"}, {17'h0, RsEx, RtEx, WriteregEx}, 0);
        check({tag, "_ctrl"}, {23'h0, RegWriteEx, MemReadEx, MemWriteEx, MemtoRegEx,
                               ALUSrcEx, ALUOpEx}, 0);
        check({tag, "_hazard"}, 32'(LoadUseHazard), 0);
    endtask

    // Asynchronous reset asserted mid-cycle.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        model = '0;
        @(posedge clk);
        #1 check_all_zero("reset_held");
    endtask

    // Monitor: compare every registered update against the scoreboard.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("ValidEx", 32'(ValidEx), 32'(e.ex.valid));
            check("RsEx", 32'(RsEx), 32'(e.ex.rs));
            check("RtEx", 32'(RtEx), 32'(e.ex.rt));
            check("WriteregEx", 32'(WriteregEx), 32'(e.ex.wreg));
            check("OperandAEx", OperandAEx, e.ex.opa);
            check("OperandBEx", OperandBEx, e.ex.opb);
            check("ImmEx", ImmEx, e.ex.imm);
            check("ctrl", {27'h0, RegWriteEx, MemReadEx, MemWriteEx, MemtoRegEx, ALUSrcEx},
                  {27'h0, e.ex.regwrite, e.ex.memread, e.ex.memwrite, e.ex.memtoreg,
                   e.ex.alusrc});
            check("ALUOpEx", 32'(ALUOpEx), 32'(e.ex.aluop));
            check("LoadUseHazard", 32'(LoadUseHazard), 32'(e.hazard));
        end
    end

    function automatic stim_t rand_stim();
        stim_t s;
        s.stall    = ($urandom_range(0, 3) == 0);
        s.flush    = ($urandom_range(0, 7) == 0);
        s.rs       = 5'($urandom_range(0, 7));
        s.rt       = 5'($urandom_range(0, 7));
        s.rd       = 5'($urandom);
        s.d1       = $urandom;
        s.d2       = $urandom;
        s.imm      = 16'($urandom);
        s.ext      = 1'($urandom);
        s.regwrite = 1'($urandom);
        s.memread  = 1'($urandom);
        s.memwrite = 1'($urandom);
        s.memtoreg = 1'($urandom);
        s.alusrc   = 1'($urandom);
        s.regdst   = 1'($urandom);
        s.aluop    = 4'($urandom);
        s.wbwe     = 1'($urandom);
        s.wreg     = 5'($urandom_range(0, 7));
        s.wdata    = $urandom;
        return s;
    endfunction

    initial begin
        stim_t s;
        model = '0;
        {Stall, Flush, ExtOp, RegWriteIn, MemReadIn, MemWriteIn, MemtoRegIn, ALUSrcIn,
         RegDstIn, WbRegWrite} = '0;
        {Readregister1, Readregister2, RdIn, WbWriteregister} = '0;
        {Readdata1, Readdata2, WbWritedata} = '0;
        ImmIn = '0; ALUOpIn = '0;
        #3 check_all_zero("reset_initial");

        // Plain load, sign and zero extension.
        s = '0;
        s.rs = 3; s.d1 = 32'h11; s.rt = 4; s.d2 = 32'h22; s.regdst = 1; s.rd = 7;
        s.imm = 16'h8001; s.ext = 1;
        step(s);
        @(posedge clk);
        #2 check("plain_opa", OperandAEx, 32'h11);
        check("plain_opb", OperandBEx, 32'h22);
        check("plain_wreg", 32'(WriteregEx), 7);
        check("plain_sext", ImmEx, 32'hFFFF8001);
        s.ext = 0;
        step(s);
        @(posedge clk);
        #2 check("plain_zext", ImmEx, 32'h00008001);

        // Bypass and $0.
        s = '0;
        s.wbwe = 1; s.wreg = 3; s.wdata = 32'hDEAD; s.rs = 3; s.d1 = 32'h11;
        s.rt = 0; s.d2 = 32'h55;
        step(s);
        @(posedge clk);
        #2 check("bypass_opa", OperandAEx, 32'hDEAD);
        check("zero_opb", OperandBEx, 0);
        s.wreg = 0;
        step(s);
        @(posedge clk);
        #2 check("wb_zero_no_bypass", OperandAEx, 32'h11);

        // Stall refresh with rs == rt, then two more plain stalled cycles.
        s = '0;
        s.rs = 5; s.rt = 5; s.d1 = 32'h1; s.d2 = 32'h2; s.memwrite = 1; s.aluop = 4'h9;
        s.imm = 16'h1234;
        step(s);
        s.stall = 1; s.wbwe = 1; s.wreg = 5; s.wdata = 32'hBEEF; s.rs = 1; s.rt = 2;
        step(s);
        @(posedge clk);
        #2 check("stall_refresh_a", OperandAEx, 32'hBEEF);
        check("stall_refresh_b", OperandBEx, 32'hBEEF);
        s.wbwe = 0; s.aluop = 4'h3; s.imm = 16'hFFFF;
        step(s);
        step(s);
        @(posedge clk);
        #2 check("stall_hold_aluop", 32'(ALUOpEx), 32'h9);
        check("stall_hold_rs", 32'(RsEx), 5);

        // Flush wins over stall.
        s = '0;
        s.stall = 1; s.flush = 1; s.regwrite = 1; s.memread = 1;
        step(s);
        @(posedge clk);
        #2 check("flush_valid", 32'(ValidEx), 0);
        check("flush_ctrl", {27'h0, RegWriteEx, MemReadEx, MemWriteEx, MemtoRegEx, ALUSrcEx}, 0);
        s = '0;
        s.rs = 2; s.rt = 6;
        step(s);
        @(posedge clk);
        #2 check("reload_valid", 32'(ValidEx), 1);

        // Load-use.
        s = '0;
        s.memread = 1; s.rt = 8; s.rs = 1;
        step(s);
        @(posedge clk);
        #2 check("loaduse_hit", 32'(LoadUseHazard), 1);
        s.rt = 0; s.rs = 0;
        step(s);
        @(posedge clk);
        #2 check("loaduse_rt0", 32'(LoadUseHazard), 0);
        s = '0;
        s.memread = 1; s.rt = 8;
        step(s);
        s.flush = 1;
        step(s);
        @(posedge clk);
        #2 check("loaduse_flushed", 32'(LoadUseHazard), 0);

        // Reset while EX holds a valid instruction, then a normal load.
        s = '0;
        s.rs = 9; s.d1 = 32'hA5A5; s.regwrite = 1;
        step(s);
        do_reset();
        s.rs = 10; s.d1 = 32'h77;
        step(s);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            step(rand_stim());
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2 check("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
